// File: rtl/sdram_init_seq.sv
// Power-up init sequencer for SDR SDRAM: lock qualify, power-up NOPs, PRECHARGE-all,
// AUTO_REFRESH x REFRESH_COUNT, LOAD_MODE, then init_done. SDRAM_INIT_FAST_SIM_EN shortens lock/power-up.
`timescale 1ns/1ps
module sdram_init_seq #(
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned POWERUP_CYCLES     = 20000,
    parameter int unsigned TRP_CYCLES         = 2,
    parameter int unsigned TRFC_CYCLES        = 7,
    parameter int unsigned REFRESH_COUNT      = 2,
    parameter int unsigned TMRD_CYCLES        = 2,
    parameter logic [11:0] MODE_VALUE         = 12'h033
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    input  logic        reinit,
    output logic        cke,
    output logic [3:0]  cmd,
    output logic [11:0] addr,
    output logic [1:0]  ba,
    output logic        init_done,
    output logic        busy
);
`ifdef SDRAM_INIT_FAST_SIM_EN
    localparam int unsigned LOCK_N = 2;
    localparam int unsigned PWR_N  = 16;
`else
    localparam int unsigned LOCK_N = LOCK_STABLE_CYCLES;
    localparam int unsigned PWR_N  = POWERUP_CYCLES;
`endif
    localparam int unsigned TMAX0 = (TRP_CYCLES > TRFC_CYCLES) ? TRP_CYCLES : TRFC_CYCLES;
    localparam int unsigned TMAX  = (TMAX0 > TMRD_CYCLES) ? TMAX0 : TMRD_CYCLES;
    localparam int unsigned LW = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
    localparam int unsigned PW = (PWR_N > 1) ? $clog2(PWR_N) : 1;
    localparam int unsigned WW = $clog2(TMAX);
    localparam int unsigned RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_LMR     = 4'b0000;

    typedef enum logic [3:0] {
        S_WAIT_LOCK, S_LOCK_FILTER, S_POWERUP, S_PRECHARGE, S_WAIT_TRP,
        S_REFRESH, S_WAIT_TRFC, S_LOAD_MODE, S_WAIT_TMRD, S_DONE
    } state_e;

    state_e        state_q;
    logic [LW-1:0] lock_cnt_q;
    logic [PW-1:0] pwr_cnt_q;
    logic [WW-1:0] wait_cnt_q;
    logic [RW-1:0] ref_cnt_q;
    logic          cke_q, init_done_q, busy_q;
    logic [3:0]    cmd_q;
    logic [11:0]   addr_q;

    // Command states load wait_cnt with T-2: one cycle in the command state, T-1 in the wait state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_WAIT_LOCK;
            lock_cnt_q  <= '0;
            pwr_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            ref_cnt_q   <= '0;
            cke_q       <= 1'b0;
            cmd_q       <= CMD_INHIBIT;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (!pll_locked) begin
            state_q     <= S_WAIT_LOCK;
            lock_cnt_q  <= '0;
            cke_q       <= 1'b0;
            cmd_q       <= CMD_INHIBIT;
            addr_q      <= '0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cmd_q  <= CMD_NOP;
            addr_q <= '0;
            case (state_q)
                S_WAIT_LOCK: begin
                    state_q    <= S_LOCK_FILTER;
                    lock_cnt_q <= '0;
                    busy_q     <= 1'b1;
                end
                S_LOCK_FILTER: begin
                    if (lock_cnt_q == LW'(LOCK_N - 1)) begin
                        state_q   <= S_POWERUP;
                        pwr_cnt_q <= '0;
                        cke_q     <= 1'b1;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + 1'b1;
                    end
                end
                S_POWERUP: begin
                    if (pwr_cnt_q == PW'(PWR_N - 1)) begin
                        state_q    <= S_PRECHARGE;
                        cmd_q      <= CMD_PRE;
                        addr_q     <= 12'h400;
                        wait_cnt_q <= WW'(TRP_CYCLES - 2);
                        ref_cnt_q  <= '0;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 1'b1;
                    end
                end
                S_PRECHARGE: state_q <= S_WAIT_TRP;
                S_WAIT_TRP: begin
                    if (wait_cnt_q == '0) begin
                        state_q    <= S_REFRESH;
                        cmd_q      <= CMD_REF;
                        wait_cnt_q <= WW'(TRFC_CYCLES - 2);
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_REFRESH: state_q <= S_WAIT_TRFC;
                S_WAIT_TRFC: begin
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end else if (ref_cnt_q == RW'(REFRESH_COUNT - 1)) begin
                        state_q    <= S_LOAD_MODE;
                        cmd_q      <= CMD_LMR;
                        addr_q     <= MODE_VALUE;
                        wait_cnt_q <= WW'(TMRD_CYCLES - 2);
                    end else begin
                        state_q    <= S_REFRESH;
                        cmd_q      <= CMD_REF;
                        ref_cnt_q  <= ref_cnt_q + 1'b1;
                        wait_cnt_q <= WW'(TRFC_CYCLES - 2);
                    end
                end
                S_LOAD_MODE: state_q <= S_WAIT_TMRD;
                S_WAIT_TMRD: begin
                    if (wait_cnt_q == '0) begin
                        state_q     <= S_DONE;
                        init_done_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    // Re-run from PRECHARGE: the device is already powered, cke stays high.
                    if (reinit) begin
                        state_q     <= S_PRECHARGE;
                        cmd_q       <= CMD_PRE;
                        addr_q      <= 12'h400;
                        wait_cnt_q  <= WW'(TRP_CYCLES - 2);
                        ref_cnt_q   <= '0;
                        init_done_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                default: state_q <= S_WAIT_LOCK;
            endcase
        end
    end

    assign cke       = cke_q;
    assign cmd       = cmd_q;
    assign addr      = addr_q;
    assign ba        = 2'b00;
    assign init_done = init_done_q;
    assign busy      = busy_q;
endmodule
